// File: rtl/rt_ibex_hws_sequencer.sv
// -----------------------------------------------------------------------------
// rt_ibex_hws_sequencer
//
// Purpose
//   Upstream controller for the RT-IBEX hardware stacking unit. It accepts
//   interrupt entries and hardware-context mret events, stalls fetch while the
//   pipeline drains, starts the stacking unit in SAVE or RESTORE mode, waits
//   for done, acknowledges it, and finally redirects fetch to the handler
//   vector or to the restored return point. It keeps the interrupt nesting
//   depth. An mret taken while another irq is pending can tail-chain
//   straight into the next handler, with no restore and no save.
//
// Ports
//   clk_i           clock
//   rst_ni          async active-low reset (shared with the stacking unit)
//   irq_pending_i   an enabled irq is ready to be taken (level)
//   irq_enable_i    mstatus.MIE; gates new entries but not tail-chains
//   mret_i          mret committed in ID (1-cycle pulse)
//   pipe_empty_i    no outstanding LSU/multicycle op in ID/EX
//   hws_done_i      stacking unit done (held until ack + 1 cycle)
//   hws_start_o     1-cycle start pulse to the stacking unit
//   hws_mode_o      SAVE/RESTORE; changes only when leaving RUN
//   hws_ack_o       1-cycle acknowledge of done
//   fetch_stall_o   hold IF while any sequence is in progress
//   irq_ack_o       1-cycle pulse: irq taken
//   jump_handler_o  1-cycle pulse: redirect fetch to the vector
//   resume_o        1-cycle pulse: redirect fetch to the restored mepc
//   nest_depth_o    number of hardware-stacked contexts
//   busy_o          sequencer is not in RUN
//
// All outputs are registered. Every pulse is computed from the same
// transition that moves the FSM, so it appears in the first cycle of the
// destination state. For example, the ack/jump pulse is high during S_ACK.
// -----------------------------------------------------------------------------

package rt_ibex_hws_pkg;

  typedef enum logic {
    HWS_SAVE    = 1'b0,
    HWS_RESTORE = 1'b1
  } hw_stacking_mode_t;

endpackage

module rt_ibex_hws_sequencer
  import rt_ibex_hws_pkg::*;
#(
  parameter int unsigned MAX_NEST  = 4,
  parameter int unsigned DEPTH_W   = 3,
  parameter bit          TAILCHAIN = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               irq_pending_i,
  input  logic               irq_enable_i,
  input  logic               mret_i,
  input  logic               pipe_empty_i,
  input  logic               hws_done_i,
  output logic               hws_start_o,
  output hw_stacking_mode_t  hws_mode_o,
  output logic               hws_ack_o,
  output logic               fetch_stall_o,
  output logic               irq_ack_o,
  output logic               jump_handler_o,
  output logic               resume_o,
  output logic [DEPTH_W-1:0] nest_depth_o,
  output logic               busy_o
);

  typedef enum logic [3:0] {
    RUN      = 4'd0,
    S_DRAIN  = 4'd1,
    S_WAIT   = 4'd2,
    S_ACK    = 4'd3,
    S_SETTLE = 4'd4,
    R_DRAIN  = 4'd5,
    R_WAIT   = 4'd6,
    R_ACK    = 4'd7,
    R_SETTLE = 4'd8,
    T_DRAIN  = 4'd9
  } state_e;

  localparam logic [DEPTH_W-1:0] MAX_NEST_D = DEPTH_W'(MAX_NEST);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] DEPTH_ZERO = DEPTH_W'(0);

  state_e             state_r,     state_s;
  logic [DEPTH_W-1:0] depth_r,     depth_s;
  hw_stacking_mode_t  mode_r,      mode_s;
  logic               start_r,     start_s;
  logic               ack_r,       ack_s;
  logic               irq_ack_r,   irq_ack_s;
  logic               jump_r,      jump_s;
  logic               resume_r,    resume_s;
  logic               stall_r,     stall_s;

  logic               in_wait_s;
  logic               in_ack_s;
  logic               in_settle_s;

  // Next-state, next-depth, next-mode and next-pulse decode
  always_comb begin
    state_s   = state_r;
    depth_s   = depth_r;
    mode_s    = mode_r;
    start_s   = 1'b0;
    ack_s     = 1'b0;
    irq_ack_s = 1'b0;
    jump_s    = 1'b0;
    resume_s  = 1'b0;

    case (state_r)
      RUN: begin
        // A returning mret takes priority over a new entry. An mret with
        // no stacked context is not a hardware-stacked return, so it is
        // ignored here.
        if (mret_i && (depth_r != DEPTH_ZERO)) begin
          if (TAILCHAIN && irq_pending_i) begin
            // Tail-chain: the stacked context stays in place and the next
            // handler reuses it, so there is no stacking op and no mode change.
            irq_ack_s = 1'b1;
            state_s   = T_DRAIN;
          end else begin
            mode_s  = HWS_RESTORE;
            state_s = R_DRAIN;
          end
        end else if (irq_pending_i && irq_enable_i && (depth_r < MAX_NEST_D)) begin
          irq_ack_s = 1'b1;
          mode_s    = HWS_SAVE;
          state_s   = S_DRAIN;
        end else begin
          state_s = RUN;
        end
      end

      S_DRAIN: begin
        if (pipe_empty_i) begin
          start_s = 1'b1;
          state_s = S_WAIT;
        end else begin
          state_s = S_DRAIN;
        end
      end

      S_WAIT: begin
        if (hws_done_i) begin
          ack_s   = 1'b1;
          jump_s  = 1'b1;
          state_s = S_ACK;
          if (depth_r < MAX_NEST_D) begin
            depth_s = depth_r + DEPTH_ONE;
          end else begin
            depth_s = depth_r;
          end
        end else begin
          state_s = S_WAIT;
        end
      end

      S_ACK:    state_s = S_SETTLE;
      // done is still high from the unit during settle and must be ignored
      S_SETTLE: state_s = RUN;

      R_DRAIN: begin
        if (pipe_empty_i) begin
          start_s = 1'b1;
          state_s = R_WAIT;
        end else begin
          state_s = R_DRAIN;
        end
      end

      R_WAIT: begin
        if (hws_done_i) begin
          ack_s    = 1'b1;
          resume_s = 1'b1;
          state_s  = R_ACK;
          if (depth_r != DEPTH_ZERO) begin
            depth_s = depth_r - DEPTH_ONE;
          end else begin
            depth_s = depth_r;
          end
        end else begin
          state_s = R_WAIT;
        end
      end

      R_ACK:    state_s = R_SETTLE;
      R_SETTLE: state_s = RUN;

      T_DRAIN: begin
        if (pipe_empty_i) begin
          jump_s  = 1'b1;
          state_s = RUN;
        end else begin
          state_s = T_DRAIN;
        end
      end

      default: state_s = RUN;
    endcase

    stall_s = (state_s != RUN);
  end

  // State, depth, mode and output pulse registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= RUN;
      depth_r   <= DEPTH_ZERO;
      mode_r    <= HWS_SAVE;
      start_r   <= 1'b0;
      ack_r     <= 1'b0;
      irq_ack_r <= 1'b0;
      jump_r    <= 1'b0;
      resume_r  <= 1'b0;
      stall_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      depth_r   <= depth_s;
      mode_r    <= mode_s;
      start_r   <= start_s;
      ack_r     <= ack_s;
      irq_ack_r <= irq_ack_s;
      jump_r    <= jump_s;
      resume_r  <= resume_s;
      stall_r   <= stall_s;
    end
  end

  assign hws_start_o    = start_r;
  assign hws_mode_o     = mode_r;
  assign hws_ack_o      = ack_r;
  assign fetch_stall_o  = stall_r;
  assign irq_ack_o      = irq_ack_r;
  assign jump_handler_o = jump_r;
  assign resume_o       = resume_r;
  assign nest_depth_o   = depth_r;
  assign busy_o         = (state_r != RUN);

  assign in_wait_s   = (state_r == S_WAIT)   || (state_r == R_WAIT);
  assign in_ack_s    = (state_r == S_ACK)    || (state_r == R_ACK);
  assign in_settle_s = (state_r == S_SETTLE) || (state_r == R_SETTLE);

  rt_ibex_hws_sequencer_chk u_chk (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .hws_done_i  (hws_done_i),
    .in_wait_i   (in_wait_s),
    .in_ack_i    (in_ack_s),
    .in_settle_i (in_settle_s),
    .busy_i      (busy_o),
    .hws_start_i (hws_start_o),
    .hws_mode_i  (hws_mode_o)
  );

endmodule

// -----------------------------------------------------------------------------
// rt_ibex_hws_sequencer_chk
//
// Purpose
//   Protocol checks around the sequencer. Done from the stacking unit is only
//   legitimate while the unit is being waited on or acknowledged. It may
//   linger for one cycle after the settle state. The mode must stay frozen
//   for a whole sequence, and start is always a single-cycle pulse.
//
// Ports
//   clk_i, rst_ni     clock and reset of the sequencer
//   hws_done_i        done from the stacking unit
//   in_wait_i         sequencer is in S_WAIT or R_WAIT
//   in_ack_i          sequencer is in S_ACK or R_ACK
//   in_settle_i       sequencer is in S_SETTLE or R_SETTLE
//   busy_i            sequencer is not in RUN
//   hws_start_i       start pulse
//   hws_mode_i        mode toward the stacking unit
// -----------------------------------------------------------------------------
module rt_ibex_hws_sequencer_chk
  import rt_ibex_hws_pkg::*;
(
  input logic              clk_i,
  input logic              rst_ni,
  input logic              hws_done_i,
  input logic              in_wait_i,
  input logic              in_ack_i,
  input logic              in_settle_i,
  input logic              busy_i,
  input logic              hws_start_i,
  input hw_stacking_mode_t hws_mode_i
);

  // Unexpected done outside the wait/ack window
  done_window_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    hws_done_i |-> (in_wait_i || in_ack_i || in_settle_i || $past(in_settle_i)));

  // Mode is only allowed to move on the RUN exit edge
  mode_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    busy_i |=> $stable(hws_mode_i));

  // Start never lasts more than one cycle
  start_pulse_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    hws_start_i |=> !hws_start_i);

endmodule
